// File: rtl/adder_tree_feeder.sv
// Packs NUM_WORDS streamed words into the adder tree operand, starts the tree,
// waits for done (with timeout) and hands the sum to the host with valid/ack.
module adder_tree_feeder #(
  parameter int unsigned WORD_W    = 16,
  parameter int unsigned NUM_WORDS = 8,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        in_valid,
  input  logic [WORD_W-1:0]           in_data,
  output logic                        in_ready,
  input  logic                        flush,
  output logic                        tree_start,
  output logic [WORD_W*NUM_WORDS-1:0] tree_din,
  input  logic                        tree_done,
  input  logic [WORD_W-1:0]           tree_dout,
  output logic                        res_valid,
  output logic [WORD_W-1:0]           res_data,
  output logic                        res_err,
  input  logic                        res_ack,
  output logic                        busy,
  output logic [15:0]                 job_cnt
);

  localparam int unsigned OP_W  = WORD_W * NUM_WORDS;
  localparam int unsigned IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    START  = 2'd1,
    WAIT   = 2'd2,
    RESULT = 2'd3
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [OP_W-1:0]    operand;
  logic [TMR_W-1:0]   timer;
  logic [WORD_W-1:0]  res_data_q;
  logic               res_err_q;
  logic [15:0]        job_cnt_q;

  // Job sequencing: fill slots, pulse start, wait for done/timeout, hold result.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= FILL;
      idx        <= '0;
      operand    <= '0;
      timer      <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
      job_cnt_q  <= '0;
    end else begin
      case (state)
        FILL: begin
          if (flush) begin
            idx     <= '0;
            operand <= '0;
          end else if (in_valid) begin
            for (int k = 0; k < NUM_WORDS; k++) begin
              if (idx == IDX_W'(k)) operand[k*WORD_W +: WORD_W] <= in_data;
            end
            if (idx == LAST_IDX) begin
              idx   <= '0;
              state <= START;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        START: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          timer <= timer + 1'b1;
          // done takes priority over a coincident timeout
          if (tree_done) begin
            res_data_q <= tree_dout;
            res_err_q  <= 1'b0;
            state      <= RESULT;
          end else if (timer == TMR_LAST) begin
            res_data_q <= '0;
            res_err_q  <= 1'b1;
            state      <= RESULT;
          end
        end
        RESULT: begin
          if (res_ack) begin
            job_cnt_q <= job_cnt_q + 1'b1;
            operand   <= '0;
            state     <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  // Every output is forced low while reset is asserted.
  assign in_ready   = rstn && (state == FILL);
  assign tree_start = rstn && (state == START);
  assign res_valid  = rstn && (state == RESULT);
  assign busy       = rstn && (state != FILL);
  assign tree_din   = {OP_W{rstn}} & operand;
  assign res_data   = {WORD_W{rstn}} & res_data_q;
  assign res_err    = rstn && res_err_q;
  assign job_cnt    = {16{rstn}} & job_cnt_q;

endmodule

// File: tb/tb_adder_tree_feeder.sv
// Scoreboard bench for adder_tree_feeder with a behavioural adder tree model.
module tb_adder_tree_feeder;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned NWORDS = 8;
  localparam int unsigned OP_W   = WORD_W * NWORDS;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              in_valid = 1'b0;
  logic [WORD_W-1:0] in_data = '0;
  logic              in_ready;
  logic              flush = 1'b0;
  logic              tree_start;
  logic [OP_W-1:0]   tree_din;
  logic              tree_done = 1'b0;
  logic [WORD_W-1:0] tree_dout = '0;
  logic              res_valid;
  logic [WORD_W-1:0] res_data;
  logic              res_err;
  logic              res_ack = 1'b0;
  logic              busy;
  logic [15:0]       job_cnt;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic              err;
  } res_t;

  res_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          tree_delay = 5;
  bit          tree_mute = 1'b0;
  logic [15:0] exp_jobs = '0;

  always #5 clk = ~clk;

  adder_tree_feeder dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .flush(flush), .tree_start(tree_start),
    .tree_din(tree_din), .tree_done(tree_done), .tree_dout(tree_dout),
    .res_valid(res_valid), .res_data(res_data), .res_err(res_err),
    .res_ack(res_ack), .busy(busy), .job_cnt(job_cnt)
  );

  task automatic check(input string tag, input logic [OP_W-1:0] got, input logic [OP_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Adder tree model: sums the operand and pulses done tree_delay cycles after start.
  initial begin : tree_model
    int          cnt;
    logic [15:0] sum;
    cnt = 0;
    sum = '0;
    forever begin
      @(negedge clk);
      tree_done = 1'b0;
      if (tree_start && !tree_mute) begin
        cnt = tree_delay;
        sum = '0;
        for (int k = 0; k < NWORDS; k++) sum = sum + 16'(tree_din >> (WORD_W * k));
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          tree_done = 1'b1;
          tree_dout = sum;
        end
      end
    end
  end

  function automatic logic [15:0] op_sum(input logic [OP_W-1:0] op);
    logic [15:0] s = '0;
    for (int k = 0; k < NWORDS; k++) s = s + 16'(op >> (WORD_W * k));
    return s;
  endfunction

  task automatic send_word(input logic [WORD_W-1:0] d);
    int b = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && b < 100) begin
      @(negedge clk);
      b++;
    end
    if (!in_ready) check("in_ready_wait", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_job(input logic [OP_W-1:0] op);
    for (int k = 0; k < NWORDS; k++) send_word(16'(op >> (WORD_W * k)));
  endtask

  task automatic cmp_result();
    res_t e;
    if (exp_q.size() == 0) begin
      check("sb_empty", exp_q.size(), 1);
    end else begin
      e = exp_q.pop_front();
      check("res_data", res_data, e.data);
      check("res_err", res_err, e.err);
    end
  endtask

  task automatic get_result(output int n);
    n = 0;
    while (!res_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("res_valid", res_valid, 1);
    cmp_result();
  endtask

  task automatic do_ack();
    res_ack = 1'b1;
    @(negedge clk);
    res_ack = 1'b0;
    exp_jobs = exp_jobs + 16'd1;
    check("job_cnt", job_cnt, exp_jobs);
    check("res_valid_after_ack", res_valid, 0);
    check("in_ready_after_ack", in_ready, 1);
  endtask

  task automatic full_job(input logic [OP_W-1:0] op);
    int n;
    exp_q.push_back('{data: op_sum(op), err: 1'b0});
    send_job(op);
    get_result(n);
    do_ack();
  endtask

  initial begin : main
    logic [OP_W-1:0] op;
    int n;

    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_job_cnt", job_cnt, 0);
    check("rst_tree_din", tree_din, 0);
    rstn = 1'b1;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);
    check("idle_busy", busy, 0);
    check("idle_res_data", res_data, 0);

    // Basic job with words 1..8
    op = '0;
    for (int k = 0; k < NWORDS; k++) op = op | (OP_W'(k + 1) << (WORD_W * k));
    exp_q.push_back('{data: 16'h0024, err: 1'b0});
    send_job(op);
    check("start_pulse", tree_start, 1);
    check("start_din", tree_din, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    check("start_busy", busy, 1);
    check("start_in_ready", in_ready, 0);
    @(negedge clk);
    check("start_one_cycle", tree_start, 0);
    get_result(n);
    do_ack();

    // Partial fill then flush; the word presented with flush is dropped
    for (int k = 0; k < 3; k++) send_word(16'h1111);
    flush = 1'b1;
    in_valid = 1'b1;
    in_data = 16'h2222;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_din", tree_din, 0);
    op = {NWORDS{16'h0010}};
    exp_q.push_back('{data: 16'h0080, err: 1'b0});
    send_job(op);
    check("flush_job_din", tree_din, op);
    get_result(n);
    do_ack();

    // Timeout: tree never answers
    tree_mute = 1'b1;
    op = '0;
    for (int k = 0; k < NWORDS; k++) op = op | (OP_W'(16'h0101 * (k + 1)) << (WORD_W * k));
    exp_q.push_back('{data: 16'h0000, err: 1'b1});
    send_job(op);
    check("to_start", tree_start, 1);
    @(negedge clk);
    get_result(n);
    check("to_latency", n, 64);
    do_ack();
    tree_mute = 1'b0;
    op = '0;
    for (int k = 0; k < NWORDS; k++) op = op | (OP_W'(16'h0100 + k) << (WORD_W * k));
    full_job(op);

    // in_valid held through START/WAIT/RESULT; result held without ack
    op = '0;
    for (int k = 0; k < NWORDS; k++) op = op | (OP_W'(3 * k + 1) << (WORD_W * k));
    exp_q.push_back('{data: op_sum(op), err: 1'b0});
    send_job(op);
    in_valid = 1'b1;
    n = 0;
    while (!res_valid && n < 100) begin
      in_data = 16'hA000 + 16'(n);
      check("hold_in_ready", in_ready, 0);
      check("hold_din", tree_din, op);
      @(negedge clk);
      n++;
    end
    check("hold_res_valid", res_valid, 1);
    cmp_result();
    for (int i = 0; i < 10; i++) begin
      in_data = 16'hB000 + 16'(i);
      check("noack_res_valid", res_valid, 1);
      check("noack_din", tree_din, op);
      @(negedge clk);
    end
    in_data = 16'h5A5A;
    res_ack = 1'b1;
    @(negedge clk);
    res_ack = 1'b0;
    exp_jobs = exp_jobs + 16'd1;
    check("hold_job_cnt", job_cnt, exp_jobs);
    check("hold_cleared_din", tree_din, 0);
    check("hold_fill_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("slot0_after_ack", tree_din, 128'h5A5A);
    exp_q.push_back('{data: 16'h5A61, err: 1'b0});
    for (int k = 1; k < NWORDS; k++) send_word(16'h0001);
    get_result(n);
    do_ack();

    // Reset in the middle of WAIT; the late done must be ignored
    op = '0;
    for (int k = 0; k < NWORDS; k++) op = op | (OP_W'(16'h0200 + k) << (WORD_W * k));
    send_job(op);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_busy", busy, 1);
    rstn = 1'b0;
    check("rst_gate_ready", in_ready, 0);
    @(negedge clk);
    rstn = 1'b1;
    exp_jobs = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_res_valid", res_valid, 0);
      check("post_rst_busy", busy, 0);
    end
    check("post_rst_ready", in_ready, 1);
    check("post_rst_job_cnt", job_cnt, 0);
    op = '0;
    for (int k = 0; k < NWORDS; k++) op = op | (OP_W'(16'h1000 * k + 16'h0077) << (WORD_W * k));
    full_job(op);

    // Counter wrap, preloaded near the top
    force dut.job_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.job_cnt_q;
    exp_jobs = 16'hFFFE;
    check("preload_job_cnt", job_cnt, 16'hFFFE);
    op = {NWORDS{16'h2000}};
    full_job(op);
    op = {NWORDS{16'h0001}};
    full_job(op);
    check("wrap_job_cnt", job_cnt, 16'h0000);
    check("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks done", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
